c_bram_read_arbiter: RTL and testbench

Shares the read port (port B) of the output-C BRAM between two requesters: requester 0 is the fault-tolerance checksum checker and requester 1 is the host readout path. It accepts burst read requests, arbitrates round-robin at burst boundaries, and drives the BRAM read address. It stalls issue while the C write controller is writing, and returns tagged read data with a last-beat flag.

---
 rtl/c_bram_read_arbiter.sv | 155 +++++++++++++++
 tb/tb_c_bram_read_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_bram_read_arbiter.sv
// ============================================================================
// Module   : c_bram_read_arbiter
// Purpose  : Round-robin burst read arbiter for port B of the output-C BRAM
//            (requester 0 = checksum checker, requester 1 = host readout).
// Option   : ARB_FIXED_PRIO_EN - requester 0 always wins when both request
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c_bram_read_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_busy,
  input  logic [1:0]          req_valid,
  input  logic [2*AW-1:0]     req_addr,
  input  logic [2*(AW+1)-1:0] req_len,
  output logic [1:0]          req_ready,
  output logic                bram_enb,
  output logic [AW-1:0]       bram_addrb,
  input  logic [DW-1:0]       bram_doutb,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic                rsp_last,
  output logic [DW-1:0]       rsp_data,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] cur_addr_q;
  logic [AW:0]   remaining_q;
  logic          rsp_id_q;
  logic          pick_both;
  logic          drain_done;
  logic          issue;
  logic          issue_last;
  logic [AW-1:0] sel_addr;
  logic [AW:0]   sel_len;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_both = 1'b0;
`else
  logic ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (state_q == ARB) begin
      ptr_q <= ~grant_q;
    end
  end

  assign pick_both = ptr_q;
`endif

  assign sel_addr   = grant_q ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign sel_len    = grant_q ? req_len[2*(AW+1)-1:AW+1] : req_len[AW:0];
  assign issue      = (state_q == ISSUE) && !wr_busy;
  assign issue_last = issue && (remaining_q == (AW+1)'(1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = ARB;
          grant_d = (&req_valid) ? pick_both : req_valid[1];
        end
      end
      ARB:     state_d = (sel_len == '0) ? IDLE : ISSUE;
      ISSUE:   if (issue_last) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_q == ARB) begin
        cur_addr_q  <= sel_addr;
        remaining_q <= sel_len;
        rsp_id_q    <= grant_q;
      end else if (issue) begin
        cur_addr_q  <= cur_addr_q + AW'(1);
        remaining_q <= remaining_q - (AW+1)'(1);
      end
    end
  end

  // Beat tracking mirrors the BRAM read latency; DRAIN ends once no beat
  // remains to appear after the current cycle.
  if (RD_LAT == 1) begin : g_lat1
    logic vld_q, last_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end else begin
        vld_q  <= issue;
        last_q <= issue_last;
      end
    end

    assign rsp_valid  = vld_q;
    assign rsp_last   = last_q;
    assign drain_done = 1'b1;
  end else begin : g_lat2
    logic [1:0] vld_q, last_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 2'b00;
        last_q <= 2'b00;
      end else begin
        vld_q  <= {vld_q[0], issue};
        last_q <= {last_q[0], issue_last};
      end
    end

    assign rsp_valid  = vld_q[1];
    assign rsp_last   = last_q[1];
    assign drain_done = !vld_q[0];
  end

  assign req_ready  = (state_q == ARB) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bram_enb   = issue;
  assign bram_addrb = cur_addr_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = bram_doutb;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_c_bram_read_arbiter.sv
// ============================================================================
// Module   : tb_c_bram_read_arbiter
// Purpose  : Directed bench for c_bram_read_arbiter (RD_LAT=1 and RD_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c_bram_read_arbiter;

  localparam int AW = 5;
  localparam int DW = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;

  logic              wr_busy = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [2*AW-1:0]   req_addr = '0;
  logic [2*AW+1:0]   req_len = '0;
  logic [1:0]        req_ready;
  logic              bram_enb;
  logic [AW-1:0]     bram_addrb;
  logic [DW-1:0]     bram_doutb = '0;
  logic              rsp_valid, rsp_id, rsp_last, busy;
  logic [DW-1:0]     rsp_data;

  logic              wr_busy2 = 1'b0;
  logic [1:0]        req_valid2 = '0;
  logic [2*AW-1:0]   req_addr2 = '0;
  logic [2*AW+1:0]   req_len2 = '0;
  logic [1:0]        req_ready2;
  logic              bram_enb2;
  logic [AW-1:0]     bram_addrb2;
  logic [DW-1:0]     bram_doutb2 = '0;
  logic [DW-1:0]     stage2 = '0;
  logic              rsp_valid2, rsp_id2, rsp_last2, busy2;
  logic [DW-1:0]     rsp_data2;

  int n_tests = 0;
  int n_fail  = 0;

  c_bram_read_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_busy(wr_busy), .req_valid(req_valid),
    .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last),
    .rsp_data(rsp_data), .busy(busy)
  );

  c_bram_read_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_busy(wr_busy2), .req_valid(req_valid2),
    .req_addr(req_addr2), .req_len(req_len2), .req_ready(req_ready2),
    .bram_enb(bram_enb2), .bram_addrb(bram_addrb2), .bram_doutb(bram_doutb2),
    .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_last(rsp_last2),
    .rsp_data(rsp_data2), .busy(busy2)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int r);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(r) * 32'h0001_0101;
    return {32{w}};
  endfunction

  // BRAM port-B models: one- and two-cycle read latency
  always @(posedge clk) begin
    if (bram_enb) bram_doutb <= pat(int'(bram_addrb));
    if (bram_enb2) stage2 <= pat(int'(bram_addrb2));
    bram_doutb2 <= stage2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed low word %0h expected low word %0h", tag, obs[31:0], exp[31:0]);
    end
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    int n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == 2'b00 && n < 20);
    chk(tag, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || busy2) && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy | busy2), 32'd0);
  endtask

  // Entered in the ARB cycle of a granted burst on dut (RD_LAT=1)
  task automatic check_burst(input string tag, input logic id, input int a0, input int len);
    chk({tag, "_ready"}, 32'(req_ready), id ? 32'd2 : 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req_valid = 2'b00;
    for (int k = 0; k < len; k++) begin
      tick();
      chk({tag, "_enb"}, 32'(bram_enb), 32'd1);
      chk({tag, "_addr"}, 32'(bram_addrb), 32'((a0 + k) % 32));
      chk({tag, "_vld"}, 32'(rsp_valid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_last"}, 32'(rsp_last), 32'd0);
        chkd({tag, "_data"}, rsp_data, pat((a0 + k - 1) % 32));
      end
    end
    tick();
    chk({tag, "_enb_end"}, 32'(bram_enb), 32'd0);
    chk({tag, "_vld_end"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_last_end"}, 32'(rsp_last), 32'd1);
    chk({tag, "_id_end"}, 32'(rsp_id), 32'(id));
    chkd({tag, "_data_end"}, rsp_data, pat((a0 + len - 1) % 32));
    chk({tag, "_busy_drain"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_vld_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  logic [1:0] exp_second;

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    exp_second = 2'b01;
`else
    exp_second = 2'b10;
`endif
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_enb", 32'(bram_enb), 32'd0);
    chk("rst_addr", 32'(bram_addrb), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_last", 32'(rsp_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Contention: both requesters keep requesting single-row bursts
    req_addr  = {5'd9, 5'd2};
    req_len   = {6'd1, 6'd1};
    req_valid = 2'b11;
    wait_grant("cont_g1", 2'b01);
    wait_grant("cont_g2", exp_second);
    wait_grant("cont_g3", 2'b01);
    req_valid = 2'b00;
    wait_idle("cont_idle");

    // Single burst on requester 0
    req_addr  = {5'd0, 5'd3};
    req_len   = {6'd0, 6'd4};
    req_valid = 2'b01;
    tick();
    check_burst("single", 1'b0, 3, 4);

    // Write stall after the first issue
    req_addr  = {5'd0, 5'd10};
    req_len   = {6'd0, 6'd3};
    req_valid = 2'b01;
    tick();
    chk("stall_ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    tick();
    chk("stall_enb0", 32'(bram_enb), 32'd1);
    chk("stall_addr0", 32'(bram_addrb), 32'd10);
    tick();
    wr_busy = 1'b1;
    #1;
    chk("stall_enb_hold", 32'(bram_enb), 32'd0);
    chk("stall_beat1", 32'(rsp_valid), 32'd1);
    chkd("stall_data1", rsp_data, pat(10));
    chk("stall_addr_hold", 32'(bram_addrb), 32'd11);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_enb_low", 32'(bram_enb), 32'd0);
      chk("stall_gap", 32'(rsp_valid), 32'd0);
    end
    tick();
    chk("stall_gap5", 32'(rsp_valid), 32'd0);
    wr_busy = 1'b0;
    #1;
    chk("stall_resume_enb", 32'(bram_enb), 32'd1);
    chk("stall_resume_addr", 32'(bram_addrb), 32'd11);
    tick();
    chk("stall_beat2", 32'(rsp_valid), 32'd1);
    chkd("stall_data2", rsp_data, pat(11));
    chk("stall_addr2", 32'(bram_addrb), 32'd12);
    chk("stall_last2", 32'(rsp_last), 32'd0);
    tick();
    chk("stall_beat3", 32'(rsp_valid), 32'd1);
    chk("stall_last3", 32'(rsp_last), 32'd1);
    chkd("stall_data3", rsp_data, pat(12));
    chk("stall_enb3", 32'(bram_enb), 32'd0);
    tick();
    chk("stall_idle", 32'(busy), 32'd0);

    // Address wrap on requester 1
    req_addr  = {5'd30, 5'd0};
    req_len   = {6'd4, 6'd0};
    req_valid = 2'b10;
    tick();
    check_burst("wrap", 1'b1, 30, 4);

    // Zero-length burst on requester 1
    req_addr  = {5'd7, 5'd0};
    req_len   = {6'd0, 6'd0};
    req_valid = 2'b10;
    tick();
    chk("len0_ready", 32'(req_ready), 32'd2);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_enb_arb", 32'(bram_enb), 32'd0);
    req_valid = 2'b00;
    tick();
    chk("len0_idle", 32'(busy), 32'd0);
    chk("len0_enb", 32'(bram_enb), 32'd0);
    chk("len0_ready_off", 32'(req_ready), 32'd0);
    tick();
    chk("len0_vld", 32'(rsp_valid), 32'd0);

    // Reset mid-burst on the RD_LAT=2 instance
    req_addr2  = {5'd5, 5'd0};
    req_len2   = {6'd4, 6'd0};
    req_valid2 = 2'b10;
    tick();
    chk("lat2_ready", 32'(req_ready2), 32'd2);
    req_valid2 = 2'b00;
    tick();
    chk("lat2_addr", 32'(bram_addrb2), 32'd5);
    tick();
    chk("lat2_not_yet", 32'(rsp_valid2), 32'd0);
    tick();
    chk("lat2_beat1", 32'(rsp_valid2), 32'd1);
    chk("lat2_id", 32'(rsp_id2), 32'd1);
    chkd("lat2_data", rsp_data2, pat(5));
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(rsp_valid2), 32'd0);
    chk("mrst_busy", 32'(busy2), 32'd0);
    chk("mrst_enb", 32'(bram_enb2), 32'd0);
    chk("mrst_addr", 32'(bram_addrb2), 32'd0);
    chk("mrst_id", 32'(rsp_id2), 32'd0);
    chk("mrst_last", 32'(rsp_last2), 32'd0);
    chk("mrst_ready", 32'(req_ready2), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mrst_no_rsp", 32'(rsp_valid2), 32'd0);
    end
    chk("mrst_idle", 32'(busy2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
